// File: rtl/rom_image_writer_if.sv
// ---------------------------------------------------------------------------
// rom_image_writer_if
//   Bundles the burst-control, row-beat handshake and debug readback signals
//   of rom_image_writer.
//   master : drives start/base_addr/num_rows, din_valid/din and rd_addr;
//            observes din_ready, busy, done, err and rd_dout.
//   slave  : the writer itself (mirror of master).
// ---------------------------------------------------------------------------
interface rom_image_writer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16
);
    logic                             start;
    logic [ADDR_WIDTH-1:0]            base_addr;
    logic [ADDR_WIDTH-1:0]            num_rows;
    logic                             din_valid;
    logic [DATA_WIDTH*NUM_BANKS-1:0]  din;
    logic                             din_ready;
    logic                             busy;
    logic                             done;
    logic                             err;
    logic [ADDR_WIDTH-1:0]            rd_addr;
    logic [DATA_WIDTH-1:0]            rd_dout;

    modport master (
        output start, base_addr, num_rows, din_valid, din, rd_addr,
        input  din_ready, busy, done, err, rd_dout
    );

    modport slave (
        input  start, base_addr, num_rows, din_valid, din, rd_addr,
        output din_ready, busy, done, err, rd_dout
    );
endinterface

// File: rtl/rom_image_writer.sv
// ---------------------------------------------------------------------------
// rom_image_writer
//   Writes NUM_BANKS-byte row beats into an on-chip byte RAM at consecutive
//   addresses, lane 0 at the lowest address, so a banked ROM read at the row
//   start address returns the beat unchanged. Used to build weight/activation
//   images for the systolic array.
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (control, counters, rd_dout)
//   bus    : rom_image_writer_if.slave
//            start/base_addr/num_rows - burst request, sampled in IDLE only
//            din_valid/din/din_ready  - row-beat handshake
//            busy/done/err            - status (done is a 1-cycle pulse,
//                                       err is sticky until the next burst)
//            rd_addr/rd_dout          - registered single-byte readback
// ---------------------------------------------------------------------------
module rom_image_writer #(
    parameter int ADDR_WIDTH = 9,
    parameter int ADDR_LINE  = 432,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_image_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rows_left;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rd_dout_q;

    logic [DATA_WIDTH-1:0]   mem [ADDR_LINE];

    logic                    start_go;
    logic                    accept;
    logic [ADDR_WIDTH:0]     end_addr;
    logic                    in_bounds;
    logic [ADDR_WIDTH-1:0]   wr_addr_nxt;
    logic                    rd_in_range;

    // din_ready is decoded from the state register only, so acceptance never
    // depends combinationally on din_valid.
    assign start_go  = (state == S_IDLE) && bus.start;
    assign accept    = (state == S_WRITE) && bus.din_valid;

    // One extra bit so the end-of-row address cannot alias back into range.
    assign end_addr  = {1'b0, wr_addr} + (ADDR_WIDTH+1)'(NUM_BANKS);
    assign in_bounds = (end_addr <= (ADDR_WIDTH+1)'(ADDR_LINE));

    // Saturate rather than wrap, so later beats of an overrunning burst keep
    // landing out of range instead of overwriting address 0 onwards.
    assign wr_addr_nxt = end_addr[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}}
                                              : end_addr[ADDR_WIDTH-1:0];

    assign rd_in_range = ({1'b0, bus.rd_addr} < (ADDR_WIDTH+1)'(ADDR_LINE));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.num_rows != '0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                if (accept && (rows_left == ADDR_WIDTH'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy      = (state == S_WRITE);
        bus.din_ready = (state == S_WRITE);
        bus.done      = (state == S_DONE);
        bus.err       = err_q;
        bus.rd_dout   = rd_dout_q;
    end

    // Burst counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rows_left <= '0;
            err_q     <= 1'b0;
        end else if (start_go && (bus.num_rows != '0)) begin
            wr_addr   <= bus.base_addr;
            rows_left <= bus.num_rows;
            err_q     <= 1'b0;
        end else if (accept) begin
            // An out-of-range beat is still consumed; only its write is dropped.
            wr_addr   <= wr_addr_nxt;
            rows_left <= rows_left - ADDR_WIDTH'(1);
            if (!in_bounds) begin
                err_q <= 1'b1;
            end
        end
    end

    // Row write: all lanes or none. Memory is never cleared by reset, and a
    // beat presented during a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst_n && accept && in_bounds) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                mem[wr_addr + ADDR_WIDTH'(k)] <= bus.din[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Readback: non-blocking update gives read-before-write on a same-cycle hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dout_q <= '0;
        end else if (rd_in_range) begin
            rd_dout_q <= mem[bus.rd_addr];
        end else begin
            rd_dout_q <= '0;
        end
    end

endmodule

// File: tb/tb_rom_image_writer.sv
// ---------------------------------------------------------------------------
// tb_rom_image_writer
//   Directed bench for rom_image_writer: reset behaviour, back-to-back and
//   gapped bursts, out-of-range beat drop, zero-row burst and mid-burst reset.
//   Readback expectations live in a table of {phase, address, byte} records.
// ---------------------------------------------------------------------------
module tb_rom_image_writer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rom_image_writer_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .NUM_BANKS(16)) ifc();

    rom_image_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         phase;
        logic [8:0] addr;
        logic [7:0] exp;
    } rb_t;

    rb_t rb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_beat(input logic [7:0] s);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) begin
            b[k*8 +: 8] = s + 8'(k);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_phase(input int p);
        foreach (rb[i]) begin
            if (rb[i].phase == p) begin
                ifc.rd_addr = rb[i].addr;
                tick();
                check($sformatf("p%0d rd[%0d]", p, rb[i].addr), 32'(ifc.rd_dout), 32'(rb[i].exp));
            end
        end
    endtask

    // Runs one burst; row r carries lanes seed+16r .. seed+16r+15.
    task automatic burst(input logic [8:0] base, input logic [8:0] rows,
                         input logic [7:0] seed, input bit toggle,
                         input bit exp_err, input string nm);
        int acc;
        int cyc;
        bit v;
        bit rdy;
        ifc.start     = 1'b1;
        ifc.base_addr = base;
        ifc.num_rows  = rows;
        tick();
        ifc.start = 1'b0;
        check({nm, " busy after start"}, 32'(ifc.busy), 32'd1);
        acc = 0;
        cyc = 0;
        v   = 1'b1;
        while (acc < int'(rows) && cyc < 64) begin
            ifc.din_valid = toggle ? v : 1'b1;
            ifc.din       = mk_beat(seed + 8'(16*acc));
            if (toggle) begin
                // start while busy must have no effect
                ifc.start     = 1'b1;
                ifc.base_addr = 9'd0;
                ifc.num_rows  = 9'd1;
            end
            rdy = ifc.din_ready;
            @(posedge clk);
            #1;
            if (ifc.din_valid && rdy) begin
                acc++;
                if (acc < int'(rows)) begin
                    check($sformatf("%s done mid beat%0d", nm, acc), 32'(ifc.done), 32'd0);
                end else begin
                    check({nm, " done after last beat"}, 32'(ifc.done), 32'd1);
                    check({nm, " busy after last beat"}, 32'(ifc.busy), 32'd0);
                end
            end
            v = ~v;
            cyc++;
        end
        ifc.din_valid = 1'b0;
        ifc.start     = 1'b0;
        check({nm, " beats accepted"}, 32'(acc), 32'(rows));
        check({nm, " err"}, 32'(ifc.err), 32'(exp_err));
        tick();
        check({nm, " done cleared"}, 32'(ifc.done), 32'd0);
        check({nm, " idle busy"}, 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Readback table, hand-computed per phase.
        rb.push_back('{2, 9'd0,   8'h00});
        rb.push_back('{2, 9'd17,  8'h11});
        rb.push_back('{2, 9'd31,  8'h1F});
        rb.push_back('{2, 9'd8,   8'h08});
        rb.push_back('{2, 9'd432, 8'h00});
        rb.push_back('{2, 9'd500, 8'h00});
        rb.push_back('{3, 9'd416, 8'h40});
        rb.push_back('{3, 9'd431, 8'h4F});
        rb.push_back('{3, 9'd0,   8'h00});
        rb.push_back('{4, 9'd32,  8'h60});
        rb.push_back('{4, 9'd48,  8'h70});
        rb.push_back('{4, 9'd79,  8'h8F});
        rb.push_back('{4, 9'd31,  8'h1F});
        rb.push_back('{5, 9'd0,   8'h00});
        rb.push_back('{5, 9'd17,  8'h11});
        rb.push_back('{6, 9'd32,  8'hA0});
        rb.push_back('{6, 9'd47,  8'hAF});
        rb.push_back('{6, 9'd48,  8'h70});
        rb.push_back('{6, 9'd0,   8'hC0});
        rb.push_back('{6, 9'd15,  8'hCF});
        rb.push_back('{6, 9'd16,  8'h10});

        // 1: reset held with start and din_valid asserted
        ifc.start     = 1'b1;
        ifc.base_addr = 9'd0;
        ifc.num_rows  = 9'd1;
        ifc.din_valid = 1'b1;
        ifc.din       = mk_beat(8'hEE);
        ifc.rd_addr   = 9'd0;
        rst_n         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d busy", i),      32'(ifc.busy),      32'd0);
            check($sformatf("rst%0d din_ready", i), 32'(ifc.din_ready), 32'd0);
            check($sformatf("rst%0d done", i),      32'(ifc.done),      32'd0);
            check($sformatf("rst%0d err", i),       32'(ifc.err),       32'd0);
        end
        check("rst rd_dout", 32'(ifc.rd_dout), 32'd0);
        ifc.start     = 1'b0;
        ifc.din_valid = 1'b0;
        rst_n         = 1'b1;
        tick();
        check("post-rst busy", 32'(ifc.busy), 32'd0);

        // 2: two back-to-back beats at 0
        burst(9'd0, 9'd2, 8'h00, 1'b0, 1'b0, "t2");
        check_phase(2);

        // 3: second beat would end at 448 > 432 and is dropped
        burst(9'd416, 9'd2, 8'h40, 1'b0, 1'b1, "t3");
        check_phase(3);

        // 4: gapped beats, start pulsed while busy
        burst(9'd32, 9'd3, 8'h60, 1'b1, 1'b0, "t4");
        check_phase(4);

        // 5: zero-row burst goes straight to DONE
        ifc.start     = 1'b1;
        ifc.base_addr = 9'd0;
        ifc.num_rows  = 9'd0;
        tick();
        ifc.start = 1'b0;
        check("t5 done", 32'(ifc.done), 32'd1);
        check("t5 busy", 32'(ifc.busy), 32'd0);
        check("t5 din_ready", 32'(ifc.din_ready), 32'd0);
        tick();
        check("t5 done cleared", 32'(ifc.done), 32'd0);
        check("t5 idle busy", 32'(ifc.busy), 32'd0);
        check_phase(5);

        // 6: reset after first of four beats; row 2 presented during reset
        ifc.start     = 1'b1;
        ifc.base_addr = 9'd32;
        ifc.num_rows  = 9'd4;
        tick();
        ifc.start     = 1'b0;
        ifc.din_valid = 1'b1;
        ifc.din       = mk_beat(8'hA0);
        tick();
        check("t6 busy after beat1", 32'(ifc.busy), 32'd1);
        ifc.din = mk_beat(8'hB0);
        rst_n   = 1'b0;
        tick();
        check("t6 rst din_ready", 32'(ifc.din_ready), 32'd0);
        check("t6 rst busy", 32'(ifc.busy), 32'd0);
        check("t6 rst done", 32'(ifc.done), 32'd0);
        rst_n         = 1'b1;
        ifc.din_valid = 1'b0;
        tick();
        burst(9'd0, 9'd1, 8'hC0, 1'b0, 1'b0, "t6b");
        check_phase(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
